rtm_add_rd_gen: RTL and testbench



---
 rtl/rtm_add_rd_gen_if.sv | 42 ++++
 rtl/rtm_add_rd_gen.sv | 124 ++++++++++++
 tb/tb_rtm_add_rd_gen.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rtm_add_rd_gen_if.sv
// Request/control bundle between the Add-path read generator and its surroundings.
// The dbg_* signals expose the generator's FSM state and credit count for observation.
interface rtm_add_rd_gen_if #(
    parameter int S     = 4,
    parameter int DEPTH = 4096,
    parameter int CRED  = 8
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CRED + 1);

    logic              start;
    logic [AW-1:0]     base_addr;
    logic [AW:0]       n_rows;
    logic [S-1:0]      en_mask;
    logic              gnt;
    logic              cred_ret;

    // A request transfers on each clock edge where rd_vld_add and gnt are both high;
    // while rd_vld_add is high and gnt is low, rd_addr_add/rd_en_add/rd_last_add hold.
    logic              rd_vld_add;
    logic              rd_last_add;
    logic [S-1:0]      rd_en_add;
    logic [S*AW-1:0]   rd_addr_add;

    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        dbg_state;
    logic [CW-1:0]     dbg_credits;

    modport master (
        output start, base_addr, n_rows, en_mask, gnt, cred_ret,
        input  rd_vld_add, rd_last_add, rd_en_add, rd_addr_add,
        input  busy, done, err, dbg_state, dbg_credits
    );

    modport slave (
        input  start, base_addr, n_rows, en_mask, gnt, cred_ret,
        output rd_vld_add, rd_last_add, rd_en_add, rd_addr_add,
        output busy, done, err, dbg_state, dbg_credits
    );
endinterface

// File: rtl/rtm_add_rd_gen.sv
// Add-path read-request generator: walks a row range with modulo-DEPTH wrap, holds each
// request until granted, and bounds outstanding reads with a credit counter.
module rtm_add_rd_gen #(
    parameter int S     = 4,
    parameter int DEPTH = 4096,
    parameter int CRED  = 8
) (
    input  logic           clk,
    input  logic           rstn,
    rtm_add_rd_gen_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CRED + 1);

    localparam logic [CW-1:0] CRED_FULL = CW'(CRED);
    localparam logic [CW-1:0] CRED_ONE  = CW'(1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
    localparam logic [AW:0]   ONE_ROW   = (AW+1)'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state_q, state_nx;
    logic [AW-1:0]   addr_q, addr_nx;
    logic [AW:0]     rem_q, rem_nx;
    logic [S-1:0]    mask_q, mask_nx;
    logic [CW-1:0]   cred_q, cred_nx;
    logic            err_q, err_nx;
    logic            vld_q, last_q, busy_q, done_q, done_nx;
    logic            issue;

    assign issue = vld_q & bus.gnt;

    // Credit counter: an issue and a return in the same cycle cancel; a return with
    // the counter already full is dropped and flagged.
    always_comb begin
        cred_nx = cred_q;
        err_nx  = err_q;
        if (issue && !bus.cred_ret) begin
            cred_nx = cred_q - CRED_ONE;
        end else if (!issue && bus.cred_ret) begin
            if (cred_q == CRED_FULL) begin
                err_nx = 1'b1;
            end else begin
                cred_nx = cred_q + CRED_ONE;
            end
        end
    end

    always_comb begin
        state_nx = state_q;
        addr_nx  = addr_q;
        rem_nx   = rem_q;
        mask_nx  = mask_q;
        done_nx  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    addr_nx  = bus.base_addr;
                    rem_nx   = bus.n_rows;
                    mask_nx  = bus.en_mask;
                    state_nx = (bus.n_rows == '0) ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (issue) begin
                    addr_nx = (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_ONE;
                    rem_nx  = rem_q - ONE_ROW;
                    if (last_q) begin
                        state_nx = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (cred_nx == CRED_FULL) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Request flags are computed from next-state values so a request can issue every cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            mask_q  <= '0;
            cred_q  <= CRED_FULL;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_nx;
            addr_q  <= addr_nx;
            rem_q   <= rem_nx;
            mask_q  <= mask_nx;
            cred_q  <= cred_nx;
            err_q   <= err_nx;
            vld_q   <= (state_nx == RUN) && (cred_nx != '0);
            last_q  <= (state_nx == RUN) && (rem_nx == ONE_ROW);
            busy_q  <= (state_nx != IDLE);
            done_q  <= done_nx;
        end
    end

    assign bus.rd_vld_add  = vld_q;
    assign bus.rd_last_add = last_q;
    assign bus.rd_en_add   = mask_q;
    assign bus.rd_addr_add = {S{addr_q}};
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.dbg_state   = state_q;
    assign bus.dbg_credits = cred_q;
endmodule

// File: tb/tb_rtm_add_rd_gen.sv
// Bench for rtm_add_rd_gen: queue-based job model compared every cycle, plus literal
// expectations for the directed scenarios (basic, stall, credit limit, wrap, zero, reset).
module tb_rtm_add_rd_gen;
    localparam int S     = 4;
    localparam int DEPTH = 4096;
    localparam int CRED  = 8;
    localparam int AW    = $clog2(DEPTH);

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    rtm_add_rd_gen_if #(.S(S), .DEPTH(DEPTH), .CRED(CRED)) bus ();
    rtm_add_rd_gen #(.S(S), .DEPTH(DEPTH), .CRED(CRED)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- behavioural model ----------------
    logic [AW-1:0] exp_q[$];
    bit            m_active = 0, m_vld = 0, m_last = 0, m_busy = 0, m_done = 0, m_err = 0;
    int            m_cred = CRED;
    logic [AW-1:0] m_addr = '0;
    logic [S-1:0]  m_mask = '0;

    always @(posedge clk or negedge rstn) begin : model_p
        bit iss;
        if (!rstn) begin
            exp_q.delete();
            m_active = 0; m_vld = 0; m_last = 0; m_busy = 0; m_done = 0; m_err = 0;
            m_cred = CRED; m_addr = '0; m_mask = '0;
        end else begin
            iss = m_vld && (bus.gnt === 1'b1);
            if (iss) void'(exp_q.pop_front());
            if (iss && !bus.cred_ret) m_cred--;
            else if (!iss && bus.cred_ret) begin
                if (m_cred == CRED) m_err = 1;
                else m_cred++;
            end
            m_done = 0;
            if (!m_active) begin
                if (bus.start) begin
                    m_active = 1;
                    m_mask   = bus.en_mask;
                    for (int i = 0; i < int'(bus.n_rows); i++)
                        exp_q.push_back(AW'((int'(bus.base_addr) + i) % DEPTH));
                end
            end else if (exp_q.size() == 0 && m_cred == CRED) begin
                m_active = 0;
                m_done   = 1;
            end
            m_busy = m_active;
            m_vld  = m_active && exp_q.size() > 0 && m_cred > 0;
            m_last = (exp_q.size() == 1);
            if (exp_q.size() > 0) m_addr = exp_q[0];
        end
    end

    // ---------------- bench state ----------------
    int  t0 = 0;
    int  log_cyc[$];
    int  log_addr[$];
    int  log_last[$];
    int  done_cnt = 0, done_rel = 0, done_snap = 0;
    bit  issue_seen = 0;
    int  ret_q[$];
    bit  auto_ret = 1;
    int  ret_delay = 5;
    int  man_req = 0, man_done = 0;
    int  gnt_lo_from = -10, gnt_lo_to = -20;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] n, input logic [S-1:0] m);
        @(posedge clk); #1;
        done_snap     = done_cnt;
        bus.base_addr = b;
        bus.n_rows    = n;
        bus.en_mask   = m;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k;
        k = 0;
        while (done_cnt == done_snap && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        if (done_cnt == done_snap) chk({name, "_done_timeout"}, 64'(done_cnt - done_snap), 64'(1));
        repeat (2) @(negedge clk);
    endtask

    task automatic give_ret(input int n);
        int k;
        man_req += n;
        k = 0;
        while (man_done != man_req && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("ret_delivered", 64'(man_done), 64'(man_req));
        repeat (3) @(negedge clk);
    endtask

    task automatic check_issue(input string name, input int idx, input int ecyc, input int eaddr,
                               input int elast);
        chk({name, "_present"}, 64'(log_cyc.size() > idx), 64'(1));
        if (idx < log_cyc.size()) begin
            chk({name, "_cyc"},  64'(log_cyc[idx]),  64'(ecyc));
            chk({name, "_addr"}, 64'(log_addr[idx]), 64'(eaddr));
            chk({name, "_last"}, 64'(log_last[idx]), 64'(elast));
        end
    endtask

    initial begin
        int lb;
        int k;
        bus.start = 1'b0; bus.base_addr = '0; bus.n_rows = '0; bus.en_mask = '0;
        bus.gnt = 1'b1; bus.cred_ret = 1'b0;
        repeat (2) @(posedge clk);

        fork
            // compare process: DUT against model every cycle
            forever begin
                @(negedge clk);
                chk("vld",     64'(bus.rd_vld_add),  64'(m_vld));
                chk("busy",    64'(bus.busy),        64'(m_busy));
                chk("done",    64'(bus.done),        64'(m_done));
                chk("err",     64'(bus.err),         64'(m_err));
                chk("credits", 64'(bus.dbg_credits), 64'(m_cred));
                if (m_vld) begin
                    chk("addr", 64'(bus.rd_addr_add), 64'({S{m_addr}}));
                    chk("last", 64'(bus.rd_last_add), 64'(m_last));
                    chk("en",   64'(bus.rd_en_add),   64'(m_mask));
                end
                issue_seen = rstn && bus.rd_vld_add && bus.gnt;
                if (issue_seen) begin
                    log_cyc.push_back(cyc - t0 + 1);
                    log_addr.push_back(int'(bus.rd_addr_add[AW-1:0]));
                    log_last.push_back(int'(bus.rd_last_add));
                end
                if (bus.done) begin
                    done_cnt++;
                    done_rel = cyc - t0 + 1;
                end
            end
            // driver process: grant window and credit returns
            forever begin
                @(posedge clk); #1;
                if (!rstn) begin
                    ret_q.delete();
                    bus.cred_ret = 1'b0;
                end else begin
                    if (issue_seen && auto_ret) ret_q.push_back(cyc + ret_delay - 1);
                    bus.cred_ret = 1'b0;
                    if (ret_q.size() > 0 && ret_q[0] <= cyc) begin
                        bus.cred_ret = 1'b1;
                        void'(ret_q.pop_front());
                    end else if (man_done != man_req) begin
                        bus.cred_ret = 1'b1;
                        man_done++;
                    end
                end
                bus.gnt = !((cyc - t0 + 1) >= gnt_lo_from && (cyc - t0 + 1) <= gnt_lo_to);
            end
        join_none

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_vld",  64'(bus.rd_vld_add),  64'(0));
        chk("rst_busy", 64'(bus.busy),        64'(0));
        chk("rst_err",  64'(bus.err),         64'(0));
        chk("rst_cred", 64'(bus.dbg_credits), 64'(8));
        chk("rst_addr", 64'(bus.rd_addr_add), 64'(0));
        @(posedge clk); #2 rstn = 1'b1;

        // basic run
        lb = log_cyc.size();
        do_start(12'h010, 13'd3, 4'hF);
        wait_done("basic", 100);
        chk("basic_count", 64'(log_cyc.size() - lb), 64'(3));
        check_issue("basic0", lb,     1, 'h010, 0);
        check_issue("basic1", lb + 1, 2, 'h011, 0);
        check_issue("basic2", lb + 2, 3, 'h012, 1);
        chk("basic_done_cyc", 64'(done_rel), 64'(9));

        // grant stall in cycles 2-3
        gnt_lo_from = 2; gnt_lo_to = 3;
        lb = log_cyc.size();
        do_start(12'h010, 13'd3, 4'hF);
        wait_done("stall", 100);
        chk("stall_count", 64'(log_cyc.size() - lb), 64'(3));
        check_issue("stall0", lb,     1, 'h010, 0);
        check_issue("stall1", lb + 1, 4, 'h011, 0);
        check_issue("stall2", lb + 2, 5, 'h012, 1);
        chk("stall_done_cyc", 64'(done_rel), 64'(11));
        gnt_lo_from = -10; gnt_lo_to = -20;

        // address wrap
        lb = log_cyc.size();
        do_start(12'hFFE, 13'd4, 4'b0101);
        wait_done("wrap", 100);
        check_issue("wrap0", lb,     1, 'hFFE, 0);
        check_issue("wrap1", lb + 1, 2, 'hFFF, 0);
        check_issue("wrap2", lb + 2, 3, 'h000, 0);
        check_issue("wrap3", lb + 3, 4, 'h001, 1);
        chk("wrap_done_cyc", 64'(done_rel), 64'(10));

        // zero length
        lb = log_cyc.size();
        do_start(12'h123, 13'd0, 4'hF);
        wait_done("zero", 50);
        chk("zero_count", 64'(log_cyc.size() - lb), 64'(0));
        chk("zero_done_cyc", 64'(done_rel), 64'(2));

        // start while busy is ignored
        lb = log_cyc.size();
        do_start(12'h100, 13'd4, 4'hF);
        @(posedge clk); #1;
        bus.base_addr = 12'h200; bus.n_rows = 13'd2; bus.en_mask = 4'b0011; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done("busystart", 100);
        chk("busystart_count", 64'(log_cyc.size() - lb), 64'(4));
        check_issue("busystart0", lb,     1, 'h100, 0);
        check_issue("busystart3", lb + 3, 4, 'h103, 1);
        chk("busystart_done_cyc", 64'(done_rel), 64'(10));

        // credit limit with manual returns
        auto_ret = 0;
        lb = log_cyc.size();
        do_start(12'h300, 13'd12, 4'hF);
        repeat (15) @(negedge clk);
        chk("cred_issue8", 64'(log_cyc.size() - lb), 64'(8));
        chk("cred_zero",   64'(bus.dbg_credits),     64'(0));
        chk("cred_vld_lo", 64'(bus.rd_vld_add),      64'(0));
        check_issue("cred7", lb + 7, 8, 'h307, 0);
        give_ret(1);
        chk("cred_issue9", 64'(log_cyc.size() - lb), 64'(9));
        give_ret(2);
        chk("cred_issue11", 64'(log_cyc.size() - lb), 64'(11));
        chk("cred_zero2",   64'(bus.dbg_credits),     64'(0));
        give_ret(9);
        wait_done("cred", 100);
        chk("cred_issue12", 64'(log_cyc.size() - lb), 64'(12));
        check_issue("cred11", lb + 11, log_cyc.size() > lb + 11 ? log_cyc[lb + 11] : 0, 'h30B, 1);
        give_ret(1);
        chk("err_set",  64'(bus.err),         64'(1));
        chk("err_cred", 64'(bus.dbg_credits), 64'(8));

        // reset mid-job
        auto_ret = 1;
        lb = log_cyc.size();
        do_start(12'h040, 13'd6, 4'hF);
        k = 0;
        while (log_cyc.size() - lb < 2 && k < 50) begin
            @(negedge clk); #1;
            k++;
        end
        chk("midrst_two_issues", 64'(log_cyc.size() - lb), 64'(2));
        @(posedge clk); #2 rstn = 1'b0;
        #1;
        chk("midrst_vld",  64'(bus.rd_vld_add),  64'(0));
        chk("midrst_last", 64'(bus.rd_last_add), 64'(0));
        chk("midrst_busy", 64'(bus.busy),        64'(0));
        chk("midrst_err",  64'(bus.err),         64'(0));
        chk("midrst_cred", 64'(bus.dbg_credits), 64'(8));
        chk("midrst_addr", 64'(bus.rd_addr_add), 64'(0));
        chk("midrst_en",   64'(bus.rd_en_add),   64'(0));
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;

        lb = log_cyc.size();
        do_start(12'h010, 13'd3, 4'hF);
        wait_done("after_rst", 100);
        chk("after_rst_count", 64'(log_cyc.size() - lb), 64'(3));
        check_issue("after_rst0", lb,     1, 'h010, 0);
        check_issue("after_rst2", lb + 2, 3, 'h012, 1);
        chk("after_rst_done_cyc", 64'(done_rel), 64'(9));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
